// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared op encodings, FSM state type and op classification helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7
    } mem_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op <= 4'd4);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd7);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic r;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = lo[0];
            OP_LW, OP_SW:         r = |lo;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : store byte-enable/data replication and load lane extract/extend
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [3:0]  st_op_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o,
    input  logic [3:0]  ld_op_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        wen_o   = 4'b0000;
        wdata_o = st_data_i;
        case (st_op_i)
            OP_SB: begin
                wen_o   = 4'b0001 << st_addr_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            OP_SH: begin
                wen_o   = st_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            OP_SW:   wen_o = 4'b1111;
            default: wen_o = 4'b0000;
        endcase
    end

    always_comb begin
        w_byte = rdata_i[{ld_addr_i, 3'b000} +: 8];
        w_half = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_op_i)
            OP_LB:   ld_data_o = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  ld_data_o = {24'd0, w_byte};
            OP_LH:   ld_data_o = {{16{w_half[15]}}, w_half};
            OP_LHU:  ld_data_o = {16'd0, w_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// mem_access : MEM-stage data memory access unit (alignment, errors, load stall)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rset,
    input  logic        req_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        flush,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr,
    output logic        stall_out
);

    localparam logic [CNT_W-1:0] c_wait_cycles = CNT_W'(WAIT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q;
    logic [1:0]       alo_q;
    logic             load_valid_q, adel_q, ades_q;
    logic [31:0]      load_data_q, badvaddr_q;

    logic        w_idle_req, w_mis, w_ld_go, w_st_go, w_err, w_done;
    logic [3:0]  w_wen;
    logic [31:0] w_wdata, w_ld_data;

    // rset also gates the request decode so SRAM outputs are quiet while in reset
    assign w_idle_req = rset && (state_q == ST_IDLE) && req_valid && !flush;
    assign w_mis      = misaligned(mem_op, addr_in[1:0]);
    assign w_ld_go    = w_idle_req && is_load(mem_op) && !w_mis;
    assign w_st_go    = w_idle_req && is_store(mem_op) && !w_mis;
    assign w_err      = w_idle_req && w_mis;
    assign w_done     = (state_q == ST_WAIT) && !flush && (cnt_q == c_wait_cycles);

    mem_lane_align u_align (
        .st_op_i   (mem_op),
        .st_addr_i (addr_in[1:0]),
        .st_data_i (wdata_in),
        .wen_o     (w_wen),
        .wdata_o   (w_wdata),
        .ld_op_i   (op_q),
        .ld_addr_i (alo_q),
        .rdata_i   (data_sram_rdata),
        .ld_data_o (w_ld_data)
    );

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_ld_go) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (flush || w_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The final WAIT cycle releases the stall so upstream advances as the result lands
    always_comb begin
        data_sram_en    = w_ld_go || w_st_go;
        data_sram_wen   = w_st_go ? w_wen : 4'b0000;
        data_sram_addr  = data_sram_en ? {addr_in[31:2], 2'b00} : 32'd0;
        data_sram_wdata = w_st_go ? w_wdata : 32'd0;
        stall_out       = !(w_ld_go || ((state_q == ST_WAIT) && (cnt_q != c_wait_cycles)));
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            op_q         <= 4'd0;
            alo_q        <= 2'd0;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'd0;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            badvaddr_q   <= 32'd0;
        end else begin
            load_valid_q <= w_done;
            adel_q       <= w_err && is_load(mem_op);
            ades_q       <= w_err && is_store(mem_op);
            if (w_ld_go) begin
                op_q  <= mem_op;
                alo_q <= addr_in[1:0];
            end
            if (w_done) begin
                load_data_q <= w_ld_data;
            end
            if (w_err) begin
                badvaddr_q <= addr_in;
            end
        end
    end

    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign adel       = adel_q;
    assign ades       = ades_q;
    assign badvaddr   = badvaddr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// tb_mem_access : scoreboard bench for mem_access (WAIT_CYCLES=1 and 3 instances)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rset, req_valid, req3, flush;
    logic [3:0]  mem_op;
    logic [31:0] addr_in, wdata_in, rdata;

    logic        en1, lv1, adel1, ades1, stall1;
    logic [3:0]  wen1;
    logic [31:0] addr1, wdata1, ld1, bad1;
    logic        en3, lv3, adel3, ades3, stall3;
    logic [3:0]  wen3;
    logic [31:0] addr3, wdata3, ld3, bad3;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q1[$];
    logic [31:0] q3[$];

    always #5 clk = ~clk;

    mem_access #(.WAIT_CYCLES(1), .CNT_W(4)) dut (
        .clk(clk), .rset(rset), .req_valid(req_valid), .mem_op(mem_op),
        .addr_in(addr_in), .wdata_in(wdata_in), .flush(flush),
        .data_sram_en(en1), .data_sram_wen(wen1), .data_sram_addr(addr1),
        .data_sram_wdata(wdata1), .data_sram_rdata(rdata),
        .load_valid(lv1), .load_data(ld1), .adel(adel1), .ades(ades1),
        .badvaddr(bad1), .stall_out(stall1)
    );

    mem_access #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rset(rset), .req_valid(req3), .mem_op(mem_op),
        .addr_in(addr_in), .wdata_in(wdata_in), .flush(flush),
        .data_sram_en(en3), .data_sram_wen(wen3), .data_sram_addr(addr3),
        .data_sram_wdata(wdata3), .data_sram_rdata(rdata),
        .load_valid(lv3), .load_data(ld3), .adel(adel3), .ades(ades3),
        .badvaddr(bad3), .stall_out(stall3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] s;
        s = w >> (int'(a) * 8);
        case (op)
            OP_LB:   return s[7]  ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
            OP_LBU:  return s & 32'h0000_00FF;
            OP_LH:   return s[15] ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
            OP_LHU:  return s & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (lv1 === 1'b1) begin
            if (q1.size() == 0) check("load1_unexpected", 32'd1, 32'd0);
            else                check("load1_data", ld1, q1.pop_front());
        end
        if (lv3 === 1'b1) begin
            if (q3.size() == 0) check("load3_unexpected", 32'd1, 32'd0);
            else                check("load3_data", ld3, q3.pop_front());
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        req_valid = v;
        mem_op    = op;
        addr_in   = a;
        wdata_in  = d;
    endtask

    task automatic run_loads(input int n);
        logic [3:0]  op;
        logic [1:0]  lo;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 4));
            lo = 2'($urandom_range(0, 3));
            if (op == OP_LH || op == OP_LHU) lo[0] = 1'b0;
            if (op == OP_LW) lo = 2'b00;
            a = 32'h0000_0300 | {30'd0, lo};
            drive(1'b1, op, a, 32'd0);
            rdata = $urandom;
            q1.push_back(ref_load(op, lo, rdata));
            drive(1'b1, op, a ^ 32'h0000_0003, 32'd0);
        end
        drive(1'b0, OP_LB, 32'd0, 32'd0);
    endtask

    initial begin
        logic [3:0] stall_pat;
        rset = 1'b0; req_valid = 1'b0; req3 = 1'b0; flush = 1'b0;
        mem_op = OP_LB; addr_in = 32'd0; wdata_in = 32'd0; rdata = 32'd0;

        @(negedge clk);
        check("rst_stall", {31'd0, stall1}, 32'd1);
        check("rst_lv", {31'd0, lv1}, 32'd0);
        check("rst_ldata", ld1, 32'd0);
        check("rst_en", {31'd0, en1}, 32'd0);
        check("rst_badv", bad1, 32'd0);
        @(posedge clk);
        #1 rset = 1'b1;

        drive(1'b1, OP_SW, 32'h100, 32'h1234_5678);
        @(negedge clk);
        check("sw_en", {31'd0, en1}, 32'd1);
        check("sw_wen", {28'd0, wen1}, 32'hF);
        check("sw_addr", addr1, 32'h100);
        check("sw_wdata", wdata1, 32'h1234_5678);
        check("sw_stall", {31'd0, stall1}, 32'd1);

        drive(1'b1, OP_SB, 32'h103, 32'h0000_00AB);
        @(negedge clk);
        check("sb_wen", {28'd0, wen1}, 32'h8);
        check("sb_wdata", wdata1, 32'hABAB_ABAB);
        check("sb_addr", addr1, 32'h100);

        drive(1'b1, OP_SH, 32'h202, 32'h0000_BEEF);
        @(negedge clk);
        check("sh_wen", {28'd0, wen1}, 32'hC);
        check("sh_wdata", wdata1, 32'hBEEF_BEEF);

        rdata = 32'h80FF_0000;
        drive(1'b1, OP_LB, 32'h102, 32'd0);
        @(negedge clk);
        check("lb_req_stall", {31'd0, stall1}, 32'd0);
        check("lb_req_en", {31'd0, en1}, 32'd1);
        check("lb_req_wen", {28'd0, wen1}, 32'd0);
        q1.push_back(32'hFFFF_FFFF);
        drive(1'b1, OP_LB, 32'h101, 32'd0);
        @(negedge clk);
        check("lb_wait_stall", {31'd0, stall1}, 32'd1);
        check("lb_wait_en", {31'd0, en1}, 32'd0);
        drive(1'b1, OP_LBU, 32'h102, 32'd0);
        @(negedge clk);
        check("b2b_accept_en", {31'd0, en1}, 32'd1);
        q1.push_back(32'h0000_00FF);
        drive(1'b0, OP_LB, 32'd0, 32'd0);
        @(negedge clk);
        check("lbu_wait_stall", {31'd0, stall1}, 32'd1);

        run_loads(10);

        drive(1'b1, OP_LW, 32'h102, 32'd0);
        @(negedge clk);
        check("adel_en", {31'd0, en1}, 32'd0);
        check("adel_stall", {31'd0, stall1}, 32'd1);
        drive(1'b1, OP_SH, 32'h101, 32'd0);
        @(negedge clk);
        check("adel_pulse", {31'd0, adel1}, 32'd1);
        check("adel_badv", bad1, 32'h102);
        check("ades_en", {31'd0, en1}, 32'd0);
        check("ades_wen", {28'd0, wen1}, 32'd0);
        drive(1'b0, OP_LB, 32'd0, 32'd0);
        @(negedge clk);
        check("ades_pulse", {31'd0, ades1}, 32'd1);
        check("adel_cleared", {31'd0, adel1}, 32'd0);
        check("ades_badv", bad1, 32'h101);
        @(negedge clk);
        check("ades_cleared", {31'd0, ades1}, 32'd0);
        check("badv_held", bad1, 32'h101);

        flush = 1'b1;
        drive(1'b1, OP_LW, 32'h206, 32'd0);
        @(negedge clk);
        check("flush_mis_en", {31'd0, en1}, 32'd0);
        drive(1'b1, OP_LW, 32'h204, 32'd0);
        @(negedge clk);
        check("flush_err_sup", {31'd0, adel1}, 32'd0);
        check("flush_ld_en", {31'd0, en1}, 32'd0);
        check("flush_ld_stall", {31'd0, stall1}, 32'd1);
        drive(1'b0, OP_LB, 32'd0, 32'd0);
        flush = 1'b0;

        @(posedge clk);
        #1;
        req3 = 1'b1; mem_op = OP_LH; addr_in = 32'h0; rdata = 32'h0000_8001;
        @(negedge clk);
        check("w3_req_stall", {31'd0, stall3}, 32'd0);
        @(negedge clk);
        check("w3_wait1_stall", {31'd0, stall3}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; req3 = 1'b0;
        @(negedge clk);
        check("w3_flush_stall", {31'd0, stall3}, 32'd1);
        check("w3_flush_nolv", {31'd0, lv3}, 32'd0);
        @(negedge clk);
        check("w3_flush_nolv2", {31'd0, lv3}, 32'd0);

        @(posedge clk);
        #1;
        req3 = 1'b1; mem_op = OP_LH; addr_in = 32'h2; rdata = 32'h80FF_0000;
        q3.push_back(32'hFFFF_80FF);
        stall_pat = 4'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stall_pat[k] = stall3;
            if (k == 0) begin
                @(posedge clk);
                #1 addr_in = 32'h0;
            end
        end
        check("w3_stall_pattern", {28'd0, stall_pat}, 32'h8);
        @(posedge clk);
        #1 req3 = 1'b0;

        rdata = 32'h1122_3344;
        drive(1'b1, OP_LW, 32'h100, 32'd0);
        @(posedge clk);
        #2 rset = 1'b0;
        #1;
        check("midrst_lv", {31'd0, lv1}, 32'd0);
        check("midrst_stall", {31'd0, stall1}, 32'd1);
        check("midrst_en", {31'd0, en1}, 32'd0);
        check("midrst_badv", bad1, 32'd0);
        @(negedge clk);
        check("midrst_lv_hold", {31'd0, lv1}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rset = 1'b1;

        rdata = 32'hCAFE_F00D;
        drive(1'b1, OP_LW, 32'h104, 32'd0);
        q1.push_back(32'hCAFE_F00D);
        drive(1'b1, OP_LW, 32'h104, 32'd0);
        drive(1'b0, OP_LB, 32'd0, 32'd0);

        for (int t = 0; t < 20; t++) begin
            if (q1.size() == 0 && q3.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("drain_q1", q1.size(), 32'd0);
        check("drain_q3", q3.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
